sti_load_scheduler: RTL

Round-robin scheduler that shares one STI_DAC serializer between N word producers. It arbitrates pending requests, drives the serializer's `load`/`pi_*` configuration, and holds that configuration stable for the whole serialization. It tracks completion from `so_valid` and checks the emitted bit count. After every producer has signalled its last word, it raises `pi_end` and waits for `pixel_finish`.

---
 rtl/sti_load_scheduler.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/sti_load_scheduler.sv
// sti_load_scheduler: round-robin front end sharing one STI_DAC serializer
// between N word producers. Grants one word at a time, latches its serializer
// configuration, follows the serialization through so_valid, checks the bit
// count and finally drives pi_end until the serializer reports pixel_finish.
//
// Handshake: a producer raises req[i] with its fields stable and keeps it high
// until it sees the one-cycle gnt[i] pulse; the word is accepted on that edge
// and the producer may change or drop req[i] from the next cycle on.
module sti_load_scheduler #(
  parameter int N        = 2,
  parameter int START_TO = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req,
  input  logic [16*N-1:0]   req_data,
  input  logic [2*N-1:0]    req_length,
  input  logic [N-1:0]      req_fill,
  input  logic [N-1:0]      req_msb,
  input  logic [N-1:0]      req_low,
  input  logic [N-1:0]      req_last,
  input  logic              so_valid,
  input  logic              pixel_finish,
  output logic [N-1:0]      gnt,
  output logic              load,
  output logic [15:0]       pi_data,
  output logic [1:0]        pi_length,
  output logic              pi_fill,
  output logic              pi_msb,
  output logic              pi_low,
  output logic              pi_end,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int TW = $clog2(START_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_WAIT_DONE  = 3'd2,
    S_GAP        = 3'd3,
    S_END        = 3'd4,
    S_FINISH     = 3'd5
  } state_t;

  state_t          state, state_d;
  logic [1:0]      ptr, ptr_d;
  logic [N-1:0]    last_seen, last_seen_d;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic [5:0]      bcnt, bcnt_d;

  logic [N-1:0]    gnt_d;
  logic            load_d;
  logic [15:0]     pi_data_d;
  logic [1:0]      pi_length_d;
  logic            pi_fill_d, pi_msb_d, pi_low_d, pi_end_d;
  logic            busy_d, done_d, err_d;

  logic            any_lo, any_hi, found;
  logic [1:0]      sel_lo, sel_hi, sel;
  logic [15:0]     sel_data;
  logic [1:0]      sel_length;
  logic            sel_fill, sel_msb, sel_low;
  logic [5:0]      exp_bits;

  assign dbg_state = state;

  // Expected number of serialized bits for the word currently loaded.
  assign exp_bits = 6'({pi_length, 3'b000}) + 6'd8;

  // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
  always_comb begin
    any_lo = 1'b0;
    any_hi = 1'b0;
    sel_lo = '0;
    sel_hi = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_lo = 1'b1;
        sel_lo = 2'(i);
      end
      if (req[i] && (i >= int'(ptr))) begin
        any_hi = 1'b1;
        sel_hi = 2'(i);
      end
    end
    found = any_lo;
    sel   = any_hi ? sel_hi : sel_lo;
  end

  // Field mux for the selected requester.
  always_comb begin
    sel_data   = '0;
    sel_length = '0;
    sel_fill   = 1'b0;
    sel_msb    = 1'b0;
    sel_low    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == 2'(i)) begin
        sel_data   = req_data[16*i +: 16];
        sel_length = req_length[2*i +: 2];
        sel_fill   = req_fill[i];
        sel_msb    = req_msb[i];
        sel_low    = req_low[i];
      end
    end
  end

  // Next-state and next-output logic; every register holds unless a state acts.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    last_seen_d = last_seen | req_last;
    tcnt_d      = tcnt;
    bcnt_d      = bcnt;
    gnt_d       = '0;
    load_d      = 1'b0;
    pi_data_d   = pi_data;
    pi_length_d = pi_length;
    pi_fill_d   = pi_fill;
    pi_msb_d    = pi_msb;
    pi_low_d    = pi_low;
    pi_end_d    = pi_end;
    busy_d      = busy;
    done_d      = done;
    err_d       = err;
    case (state)
      S_IDLE: begin
        if (found) begin
          for (int i = 0; i < N; i++) begin
            gnt_d[i] = (sel == 2'(i));
          end
          load_d      = 1'b1;
          pi_data_d   = sel_data;
          pi_length_d = sel_length;
          pi_fill_d   = sel_fill;
          pi_msb_d    = sel_msb;
          pi_low_d    = sel_low;
          busy_d      = 1'b1;
          ptr_d       = (int'(sel) == N - 1) ? 2'd0 : sel + 2'd1;
          tcnt_d      = '0;
          state_d     = S_WAIT_START;
        end else if (&last_seen) begin
          pi_end_d = 1'b1;
          state_d  = S_END;
        end
      end
      S_WAIT_START: begin
        if (so_valid) begin
          bcnt_d  = 6'd1;
          state_d = S_WAIT_DONE;
        end else if (tcnt == TW'(START_TO - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (so_valid) begin
          bcnt_d = bcnt + 6'd1;
        end else begin
          if (bcnt != exp_bits) err_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      S_END: begin
        pi_end_d = 1'b1;
        if (pixel_finish) begin
          done_d  = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        pi_end_d = 1'b1;
        done_d   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      last_seen <= '0;
      tcnt      <= '0;
      bcnt      <= '0;
      gnt       <= '0;
      load      <= 1'b0;
      pi_data   <= '0;
      pi_length <= '0;
      pi_fill   <= 1'b0;
      pi_msb    <= 1'b0;
      pi_low    <= 1'b0;
      pi_end    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ptr       <= ptr_d;
      last_seen <= last_seen_d;
      tcnt      <= tcnt_d;
      bcnt      <= bcnt_d;
      gnt       <= gnt_d;
      load      <= load_d;
      pi_data   <= pi_data_d;
      pi_length <= pi_length_d;
      pi_fill   <= pi_fill_d;
      pi_msb    <= pi_msb_d;
      pi_low    <= pi_low_d;
      pi_end    <= pi_end_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule
